ifu_pcgen: RTL
==============

# ifu_pcgen

Instruction-fetch front end of the cirno9 core: owns the architectural fetch PC, issues one-outstanding fetch requests to instruction memory, and buffers each returned instruction with its PC for decode. It sits directly downstream of the branch/jump unit. It consumes the branch/jump unit's redirect triple (set-PC strobe, base, offset), computes the target, and flushes any wrong-path fetch.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `hs_if4mem_val`  out  1  fetch request valid.
- `hs_mem4if_rdy`  in  1  memory accepts the request.
- `o_mem_addr`  out  32  fetch address; meaningful only while `hs_if4mem_val` is high.
- `hs_mem4if_rsp`  in  1  response strobe; always accepted.
- `i_mem_rdata`  in  32  returned instruction word.
- `hs_if4de_val`  out  1  instruction available to decode.
- `hs_de4if_rdy`  in  1  decode accepts.
- `o_de_ir`  out  32  buffered instruction.
- `o_de_pc`  out  32  PC of `o_de_ir`.
- `i_setpc`  in  1  redirect strobe from the branch/jump unit.
- `i_pc`  in  32  redirect base.
- `i_pcadd`  in  32  redirect offset.
- `i_jalr`  in  1  redirect is a JALR; clear target bit 0.
- `o_misalign`  out  1  one-cycle misaligned-target flag; exists only when the macro is defined.

## Operation
- Target computation: `target = (i_pc + i_pcadd) mod 2^32`. If `i_jalr` is set, `target[0]` is forced to 0.
- FSM states:
  - RST: reset state.
  - REQ: `hs_if4mem_val` is high and `o_mem_addr` equals `pc`.
  - WAIT: one request is outstanding.
  - FULL: the buffer holds an instruction and no request is outstanding.
- Transitions:
  - RST goes to REQ in the first cycle with `rst` low.
  - REQ goes to WAIT on handshake.
  - WAIT goes to FULL on response. This loads `o_de_ir` from `i_mem_rdata`, loads `o_de_pc` from the request address, and sets `pc` to the request address + 4.
  - FULL goes to REQ on a decode handshake.
- `hs_if4de_val` is `buf_val & ~i_setpc`. A redirect kills the buffered instruction combinationally, so decode never takes a wrong-path instruction in the redirect cycle.
- Redirect has priority over every other event:
  - In every state, `pc` is loaded with `target`, the buffer is cleared, and the FSM goes to REQ.
  - In WAIT, or in REQ with a same-cycle memory handshake, a `drop` flag is set. The next response is discarded, and the FSM stays in WAIT until that response arrives before issuing the new request.
  - In REQ without a handshake, the next cycle presents the new address and nothing is dropped.
- A response strobe while `drop` is set clears `drop` only. There is no buffer load and no `pc` change.
- A response strobe in REQ, RST or FULL with `drop` clear is a protocol error and is ignored.
- A redirect while `rst` is high is ignored.

## Timing
- Reset values: `pc = RESET_PC`, state RST, `hs_if4mem_val = 0`, `hs_if4de_val = 0`, `o_de_ir = 32'h0000_0013` (NOP), `o_de_pc = RESET_PC`, `drop = 0`, `o_misalign = 0`.
- Reset mid-operation: all state returns to the reset values on the next edge. Any outstanding response is ignored, because it arrives in RST or REQ with `drop` clear.
- First request: `hs_if4mem_val` is high in the first cycle after `rst` falls.
- Response latency: the response arrives at least 1 cycle after the request handshake. `hs_if4de_val` is high the cycle after the response.
- Peak throughput is one instruction every 3 cycles with a 1-cycle memory. Decode back-pressure holds FULL indefinitely, with `o_de_ir` and `o_de_pc` stable.
- Redirect to first new request:
  - 1 cycle, from REQ without a handshake or from FULL.
  - In WAIT, or in REQ with a same-cycle handshake: the cycle after the dropped response.

## Configuration
- `CIRNO_IFU_MISALIGN_EN` defined:
  - A redirect with `target[1] = 1` does not load `pc`.
  - The buffer is still flushed and `drop` is set as normal.
  - `o_misalign` pulses high for 1 cycle.
  - The FSM parks in RST-like idle with `hs_if4mem_val` low until the next `i_setpc` or `rst`.
- Undefined: `target[1:0]` is forced to `2'b00` and the `o_misalign` port is absent.

## Structure
- The FSM state encoding and the NOP constant go into `cirno9_define.v` as `CIRNO_IFU_ST_*` and `CIRNO_NOP`.
- One sub-module, `ifu_tgt`: combinational target adder, JALR bit-0 clear, and misalign detection.
- The FSM, `pc`, `drop` and the buffer live in `ifu_pcgen`.

## Test plan
- Reset release with `RESET_PC = 0x80` and a 1-cycle memory returning `0x00100093` -> addresses 0x80, 0x84, 0x88 in sequence; decode sees (`0x80`, `0x00100093`) in cycle 3.
- Decode `hs_de4if_rdy` held low for 5 cycles -> no new request is issued; `o_de_ir` and `o_de_pc` stay constant; fetch resumes 1 cycle after ready.
- `i_setpc` in WAIT with `i_pc = 0x100`, `i_pcadd = 0x20` -> the pending response is dropped and is not seen by decode; the next request address is 0x120.
- `i_setpc` in FULL with `hs_de4if_rdy = 1` -> `hs_if4de_val` is low in that cycle; the next request goes to the target.
- JALR redirect with `i_pc = 0x201`, `i_pcadd = 0` -> the request address is 0x200.
- With `CIRNO_IFU_MISALIGN_EN`, a redirect to 0x202 -> `o_misalign` pulses for 1 cycle and `hs_if4mem_val` stays low. Without the macro, the same redirect fetches 0x200.

Source files
------------

// File: rtl/ifu_pcgen_pkg.sv
// ifu_pcgen_pkg: shared width, NOP constant and fetch FSM state encoding for the cirno9 fetch front end
package ifu_pcgen_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] CIRNO_NOP = 32'h0000_0013;
  typedef enum logic [2:0] {
    CIRNO_IFU_ST_RST,
    CIRNO_IFU_ST_REQ,
    CIRNO_IFU_ST_WAIT,
    CIRNO_IFU_ST_FULL,
    CIRNO_IFU_ST_IDLE
  } ifu_st_e;
endpackage

// File: rtl/ifu_pcgen_if.sv
// ifu_pcgen_if: fetch-side memory and decode handshake bundle
//   master (fetch unit): drives hs_if4mem_val, o_mem_addr, hs_if4de_val, o_de_ir, o_de_pc
//   slave (memory/decode): drives hs_mem4if_rdy, hs_mem4if_rsp, i_mem_rdata, hs_de4if_rdy
interface ifu_pcgen_if;
  import ifu_pcgen_pkg::*;
  logic            hs_if4mem_val;
  logic            hs_mem4if_rdy;
  logic [XLEN-1:0] o_mem_addr;
  logic            hs_mem4if_rsp;
  logic [XLEN-1:0] i_mem_rdata;
  logic            hs_if4de_val;
  logic            hs_de4if_rdy;
  logic [XLEN-1:0] o_de_ir;
  logic [XLEN-1:0] o_de_pc;
  modport master (
    output hs_if4mem_val, o_mem_addr, hs_if4de_val, o_de_ir, o_de_pc,
    input  hs_mem4if_rdy, hs_mem4if_rsp, i_mem_rdata, hs_de4if_rdy
  );
  modport slave (
    input  hs_if4mem_val, o_mem_addr, hs_if4de_val, o_de_ir, o_de_pc,
    output hs_mem4if_rdy, hs_mem4if_rsp, i_mem_rdata, hs_de4if_rdy
  );
endinterface

// File: rtl/ifu_pcgen_tgt.sv
// ifu_tgt: redirect target adder with JALR bit-0 clear and misalign detection
//   pc_i, add_i: redirect base and offset; jalr_i: clear bit 0
//   target_o: fetch target; misalign_o (CIRNO_IFU_MISALIGN_EN only): target bit 1 set
module ifu_tgt
  import ifu_pcgen_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] add_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] target_o
`ifdef CIRNO_IFU_MISALIGN_EN
  ,
  output logic            misalign_o
`endif
);
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] cleared;
  assign sum = pc_i + add_i;
  assign cleared = {sum[XLEN-1:1], sum[0] & ~jalr_i};
`ifdef CIRNO_IFU_MISALIGN_EN
  assign target_o = cleared;
  assign misalign_o = cleared[1];
`else
  // Without misalign reporting the target is silently word-aligned.
  assign target_o = cleared & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif
endmodule

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: cirno9 fetch front end - owns the fetch PC, one-outstanding memory fetch, one-entry decode buffer
//   clk, rst: clock and synchronous active-high reset
//   bus (ifu_pcgen_if.master): memory request/response and decode handshake
//   i_setpc, i_pc, i_pcadd, i_jalr: redirect strobe, base, offset, JALR flag
//   o_misalign: one-cycle misaligned-target pulse, present only with CIRNO_IFU_MISALIGN_EN
module ifu_pcgen
  import ifu_pcgen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  ifu_pcgen_if.master     bus,
  input  logic            i_setpc,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcadd,
  input  logic            i_jalr
`ifdef CIRNO_IFU_MISALIGN_EN
  ,
  output logic            o_misalign
`endif
);
  ifu_st_e         st_q, st_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] target;
  logic            mis;
  logic            mem_hs;
  logic            de_hs;
  logic            rsp;
  logic            pend;
`ifdef CIRNO_IFU_MISALIGN_EN
  logic            mis_q;
  ifu_tgt u_tgt (.pc_i(i_pc), .add_i(i_pcadd), .jalr_i(i_jalr), .target_o(target), .misalign_o(mis));
  always_ff @(posedge clk)
    mis_q <= rst ? 1'b0 : i_setpc & mis;
  assign o_misalign = mis_q;
`else
  ifu_tgt u_tgt (.pc_i(i_pc), .add_i(i_pcadd), .jalr_i(i_jalr), .target_o(target));
  assign mis = 1'b0;
`endif
  assign rsp = bus.hs_mem4if_rsp;
  assign mem_hs = bus.hs_if4mem_val & bus.hs_mem4if_rdy;
  assign de_hs = bus.hs_if4de_val & bus.hs_de4if_rdy;
  // A request is still in flight after this edge if one is accepted now, or one was pending and its response is not here yet.
  assign pend = mem_hs | ((st_q == CIRNO_IFU_ST_WAIT || drop_q) && !rsp);
  assign bus.hs_if4mem_val = st_q == CIRNO_IFU_ST_REQ;
  assign bus.o_mem_addr = pc_q;
  assign bus.hs_if4de_val = (st_q == CIRNO_IFU_ST_FULL) & ~i_setpc;
  assign bus.o_de_ir = ir_q;
  assign bus.o_de_pc = dpc_q;
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    ir_d = ir_q;
    dpc_d = dpc_q;
    drop_d = drop_q;
    if (i_setpc) begin
      pc_d = mis ? pc_q : target;
      drop_d = pend;
      st_d = mis ? CIRNO_IFU_ST_IDLE : pend ? CIRNO_IFU_ST_WAIT : CIRNO_IFU_ST_REQ;
    end else if (rsp && drop_q) begin
      drop_d = 1'b0;
      st_d = st_q == CIRNO_IFU_ST_WAIT ? CIRNO_IFU_ST_REQ : st_q;
    end else begin
      case (st_q)
        CIRNO_IFU_ST_RST:  st_d = CIRNO_IFU_ST_REQ;
        CIRNO_IFU_ST_REQ:  st_d = mem_hs ? CIRNO_IFU_ST_WAIT : CIRNO_IFU_ST_REQ;
        CIRNO_IFU_ST_WAIT: if (rsp) begin
          st_d = CIRNO_IFU_ST_FULL;
          ir_d = bus.i_mem_rdata;
          dpc_d = pc_q;
          pc_d = pc_q + XLEN'(4);
        end
        CIRNO_IFU_ST_FULL: st_d = de_hs ? CIRNO_IFU_ST_REQ : CIRNO_IFU_ST_FULL;
        default:           st_d = st_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= CIRNO_IFU_ST_RST;
      pc_q <= RESET_PC;
      ir_q <= CIRNO_NOP;
      dpc_q <= RESET_PC;
      drop_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      dpc_q <= dpc_d;
      drop_q <= drop_d;
    end
  end
endmodule
